// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types, opcodes, vector order and golden function for gate checkers
package gate_check_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    // {a,b} per index, index 0 in the low bits: 00, 10, 01, 11
    localparam logic [7:0] VEC_ORDER = {2'b11, 2'b01, 2'b10, 2'b00};

    function automatic logic [1:0] vec_ab(input logic [1:0] idx);
        return VEC_ORDER[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic golden(input logic [2:0] op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            default: return a | b;
        endcase
    endfunction

endpackage

// File: rtl/gate_vector_checker_if.sv
// rtl/gate_vector_checker_if.sv - stimulus/response link between checker and gate under test
interface gate_vector_checker_if;
    logic a;
    logic b;
    logic dut_out;

    modport master (output a, output b, input dut_out);
    modport slave  (input a, input b, output dut_out);
endinterface

// File: rtl/gate_golden_model.sv
// rtl/gate_golden_model.sv - combinational reference output for a two-input gate
module gate_golden_model
    import gate_check_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       exp_out
);

    assign exp_out = golden(op, a, b);

endmodule

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - sweeps the 2-input truth table into a gate and checks its output
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int GATE_OP     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    gate_vector_checker_if.master       gate,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [2:0]                  err_count,
    output logic [3:0]                  fail_vec
);

    localparam logic [2:0] OP = (GATE_OP >= 0 && GATE_OP <= 5) ? 3'(GATE_OP) : OP_OR;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state, state_next;
    logic [1:0] idx, idx_next;
    logic [7:0] hold_cnt, hold_next;
    logic       a_q, b_q, a_next, b_next;
    logic       busy_next, done_next;
    logic       exp_out, mismatch;
    logic [2:0] err_next;

    gate_golden_model u_golden (
        .op      (OP),
        .a       (a_q),
        .b       (b_q),
        .exp_out (exp_out)
    );

    assign gate.a   = a_q;
    assign gate.b   = b_q;
    assign mismatch = (state == S_SAMPLE) && (gate.dut_out != exp_out);
    assign err_next = err_count + 3'(mismatch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= 2'd0;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            hold_cnt <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        hold_next  = hold_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_DRIVE;
                    idx_next   = 2'd0;
                    hold_next  = 8'd1;
                end
            end
            S_DRIVE: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = S_SAMPLE;
                end else begin
                    hold_next = hold_cnt + 8'd1;
                end
            end
            S_SAMPLE: begin
                if (idx == 2'd3) begin
                    state_next = S_DONE;
                    hold_next  = 8'd0;
                end else begin
                    state_next = S_DRIVE;
                    idx_next   = idx + 2'd1;
                    hold_next  = 8'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without a cycle of lag
    always_comb begin
        busy_next = (state_next == S_DRIVE) || (state_next == S_SAMPLE);
        done_next = (state_next == S_DONE);
        {a_next, b_next} = busy_next ? vec_ab(idx_next) : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= 1'b0;
            b_q  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            a_q  <= a_next;
            b_q  <= b_next;
            busy <= busy_next;
            done <= done_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
        end else if (state == S_IDLE && start) begin
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
        end else if (state == S_SAMPLE) begin
            err_count <= err_next;
            if (mismatch) begin
                fail_vec[idx] <= 1'b1;
            end
            if (idx == 2'd3) begin
                pass <= (err_next == 3'd0);
            end
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb/tb_gate_vector_checker.sv - directed self-checking bench for gate_vector_checker
module tb_gate_vector_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_or = 1'b0, start_nand = 1'b0, start_min = 1'b0;
    logic stuck_or = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic       busy_or, done_or, pass_or;
    logic [2:0] err_or;
    logic [3:0] fail_or;
    logic       busy_nand, done_nand, pass_nand;
    logic [2:0] err_nand;
    logic [3:0] fail_nand;
    logic       busy_min, done_min, pass_min;
    logic [2:0] err_min;
    logic [3:0] fail_min;

    gate_vector_checker_if if_or ();
    gate_vector_checker_if if_nand ();
    gate_vector_checker_if if_min ();

    assign if_or.dut_out   = stuck_or ? 1'b0 : (if_or.a | if_or.b);
    assign if_nand.dut_out = if_nand.a | if_nand.b;
    assign if_min.dut_out  = if_min.a | if_min.b;

    always #5 clk = ~clk;

    gate_vector_checker #(.HOLD_CYCLES(10), .GATE_OP(1)) u_or (
        .clk(clk), .rst(rst), .start(start_or), .gate(if_or.master),
        .busy(busy_or), .done(done_or), .pass(pass_or),
        .err_count(err_or), .fail_vec(fail_or));

    gate_vector_checker #(.HOLD_CYCLES(10), .GATE_OP(3)) u_nand (
        .clk(clk), .rst(rst), .start(start_nand), .gate(if_nand.master),
        .busy(busy_nand), .done(done_nand), .pass(pass_nand),
        .err_count(err_nand), .fail_vec(fail_nand));

    gate_vector_checker #(.HOLD_CYCLES(2), .GATE_OP(1)) u_min (
        .clk(clk), .rst(rst), .start(start_min), .gate(if_min.master),
        .busy(busy_min), .done(done_min), .pass(pass_min),
        .err_count(err_min), .fail_vec(fail_min));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ab_of(input int i);
        case (i)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ndone;

        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_a",    32'(if_or.a), 0);
        check("rst_b",    32'(if_or.b), 0);
        check("rst_busy", 32'(busy_or), 0);
        check("rst_done", 32'(done_or), 0);
        check("rst_pass", 32'(pass_or), 0);
        check("rst_err",  32'(err_or), 0);
        check("rst_fail", 32'(fail_or), 0);

        // OR pass sweep, with start pulsed repeatedly while busy
        start_or = 1'b1;
        step();
        start_or = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            check("or_ab",   32'({if_or.a, if_or.b}), 32'(ab_of(c / 10)));
            check("or_busy", 32'(busy_or), 1);
            if (done_or) ndone++;
            start_or = (c % 7 == 3);
            step();
        end
        start_or = 1'b0;
        check("or_done",      32'(done_or), 1);
        check("or_done_busy", 32'(busy_or), 0);
        check("or_pass",      32'(pass_or), 1);
        check("or_err",       32'(err_or), 0);
        check("or_fail",      32'(fail_or), 0);
        check("or_done_ab",   32'({if_or.a, if_or.b}), 0);
        if (done_or) ndone++;
        step();
        check("or_done_pulse", 32'(done_or), 0);
        check("or_pass_hold",  32'(pass_or), 1);
        for (int c = 0; c < 5; c++) begin
            if (done_or) ndone++;
            step();
        end
        check("or_one_done", 32'(ndone), 1);

        // stuck-at-0 gate output
        stuck_or = 1'b1;
        start_or = 1'b1;
        step();
        start_or = 1'b0;
        check("stk_pass_clr", 32'(pass_or), 0);
        repeat (40) step();
        check("stk_done", 32'(done_or), 1);
        check("stk_err",  32'(err_or), 3);
        check("stk_fail", 32'(fail_or), 32'b1110);
        check("stk_pass", 32'(pass_or), 0);
        step();

        // NAND golden against an OR gate
        start_nand = 1'b1;
        step();
        start_nand = 1'b0;
        repeat (40) step();
        check("nand_done", 32'(done_nand), 1);
        check("nand_fail", 32'(fail_nand), 32'b1001);
        check("nand_err",  32'(err_nand), 2);
        check("nand_pass", 32'(pass_nand), 0);
        step();

        // reset asserted during vector 2
        start_or = 1'b1;
        step();
        start_or = 1'b0;
        repeat (25) step();
        check("mid_ab",   32'({if_or.a, if_or.b}), 32'b01);
        check("mid_busy", 32'(busy_or), 1);
        check("mid_err",  32'(err_or), 1);
        rst = 1'b1;
        #1;
        check("abort_ab",   32'({if_or.a, if_or.b}), 0);
        check("abort_busy", 32'(busy_or), 0);
        check("abort_done", 32'(done_or), 0);
        check("abort_err",  32'(err_or), 0);
        check("abort_fail", 32'(fail_or), 0);
        check("abort_pass", 32'(pass_or), 0);
        step();
        rst = 1'b0;
        stuck_or = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (done_or) ndone++;
            step();
        end
        check("abort_no_done", 32'(ndone), 0);
        start_or = 1'b1;
        step();
        start_or = 1'b0;
        repeat (40) step();
        check("rerun_done", 32'(done_or), 1);
        check("rerun_pass", 32'(pass_or), 1);
        check("rerun_fail", 32'(fail_or), 0);
        step();

        // minimum hold
        start_min = 1'b1;
        step();
        start_min = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("min_ab",   32'({if_min.a, if_min.b}), 32'(ab_of(c / 2)));
            check("min_done_lo", 32'(done_min), 0);
            step();
        end
        check("min_done", 32'(done_min), 1);
        check("min_pass", 32'(pass_min), 1);
        check("min_err",  32'(err_min), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
